// File: rtl/video_ram_arbiter.sv
// Shared video/CPU RAM arbiter: 8-phase slot cycle, video owns phases 0-3, CPU owns 4-7.
// Define VIDEO_WRAP_EN to enable hardware-scroll wrap of the video address via WRAP_SEL.
module video_ram_arbiter (
    input  logic        PIXELCLK,
    input  logic        RESET,
    input  logic [15:0] VADDR,
    input  logic [1:0]  WRAP_SEL,
    input  logic        CPU_REQ,
    input  logic        CPU_WE,
    input  logic [14:0] CPU_ADDR,
    input  logic [7:0]  CPU_WDATA,
    input  logic [7:0]  RAM_DIN,
    output logic [14:0] RAM_ADDR,
    output logic        RAM_WE,
    output logic [7:0]  RAM_DOUT,
    output logic [7:0]  CPU_RDATA,
    output logic        CPU_ACK,
    output logic [7:0]  VDATA,
    output logic        VDATA_VALID,
    output logic [2:0]  PHASE
);

    typedef enum logic [1:0] {StIdle, StWait, StAccess, StDone} cpu_state_e;

    cpu_state_e  r_state;
    cpu_state_e  w_state_d;
    logic [2:0]  r_phase;
    logic [14:0] r_ram_addr;
    logic        r_ram_we;
    logic [7:0]  r_ram_dout;
    logic        r_cpu_we;
    logic [7:0]  r_cpu_rdata;
    logic        r_cpu_ack;
    logic [7:0]  r_vdata;
    logic        r_vdata_valid;
    logic        w_enter_access;
    logic [14:0] w_video_addr;

`ifdef VIDEO_WRAP_EN
    logic [15:0] w_wrap_size;
    logic [15:0] w_wrapped;

    always_comb begin
        w_wrap_size = 16'h4000;
        unique case (WRAP_SEL)
            2'b00: w_wrap_size = 16'h4000;
            2'b01: w_wrap_size = 16'h2000;
            2'b10: w_wrap_size = 16'h5000;
            2'b11: w_wrap_size = 16'h2800;
            default: w_wrap_size = 16'h4000;
        endcase
        // Modulo-2^16 subtraction; only the low 15 bits address the RAM.
        w_wrapped    = VADDR - w_wrap_size;
        w_video_addr = VADDR[15] ? w_wrapped[14:0] : VADDR[14:0];
    end
`else
    logic w_unused;

    assign w_video_addr = VADDR[14:0];
    assign w_unused     = ^{WRAP_SEL, VADDR[15]};
`endif

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (CPU_REQ) begin
                    w_state_d = (r_phase == 3'd3) ? StAccess : StWait;
                end
            end
            StWait: begin
                if (!CPU_REQ) begin
                    w_state_d = StIdle;
                end else if (r_phase == 3'd3) begin
                    w_state_d = StAccess;
                end
            end
            StAccess: begin
                if (r_phase == 3'd7) begin
                    w_state_d = StDone;
                end
            end
            StDone: w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    assign w_enter_access = (r_state != StAccess) && (w_state_d == StAccess);

    always_ff @(posedge PIXELCLK) begin
        if (RESET) begin
            r_phase       <= 3'd0;
            r_state       <= StIdle;
            r_ram_addr    <= 15'd0;
            r_ram_we      <= 1'b0;
            r_ram_dout    <= 8'd0;
            r_cpu_we      <= 1'b0;
            r_cpu_rdata   <= 8'd0;
            r_cpu_ack     <= 1'b0;
            r_vdata       <= 8'd0;
            r_vdata_valid <= 1'b0;
        end else begin
            r_phase       <= r_phase + 3'd1;
            r_state       <= w_state_d;
            r_vdata_valid <= (r_phase == 3'd3);
            r_cpu_ack     <= (r_state == StAccess) && (r_phase == 3'd7);
            // Write strobe lands in phases 5 and 6, clear of the address edges.
            r_ram_we      <= (r_state == StAccess) && r_cpu_we &&
                             ((r_phase == 3'd4) || (r_phase == 3'd5));

            if (r_phase == 3'd3) begin
                r_vdata <= RAM_DIN;
            end

            if (r_phase == 3'd7) begin
                r_ram_addr <= w_video_addr;
            end else if (w_enter_access) begin
                r_ram_addr <= CPU_ADDR;
                r_cpu_we   <= CPU_WE;
                r_ram_dout <= CPU_WDATA;
            end

            if ((r_state == StAccess) && (r_phase == 3'd7) && !r_cpu_we) begin
                r_cpu_rdata <= RAM_DIN;
            end
        end
    end

    assign RAM_ADDR    = r_ram_addr;
    assign RAM_WE      = r_ram_we;
    assign RAM_DOUT    = r_ram_dout;
    assign CPU_RDATA   = r_cpu_rdata;
    assign CPU_ACK     = r_cpu_ack;
    assign VDATA       = r_vdata;
    assign VDATA_VALID = r_vdata_valid;
    assign PHASE       = r_phase;

endmodule

// File: tb/tb_video_ram_arbiter.sv
// Bench for video_ram_arbiter: directed scenarios plus randomized CPU traffic
// checked against a slot-level model (phase counter, latency arithmetic, shadow memory).
module tb_video_ram_arbiter;

    logic        PIXELCLK;
    logic        RESET;
    logic [15:0] VADDR;
    logic [1:0]  WRAP_SEL;
    logic        CPU_REQ;
    logic        CPU_WE;
    logic [14:0] CPU_ADDR;
    logic [7:0]  CPU_WDATA;
    logic [7:0]  RAM_DIN;
    logic [14:0] RAM_ADDR;
    logic        RAM_WE;
    logic [7:0]  RAM_DOUT;
    logic [7:0]  CPU_RDATA;
    logic        CPU_ACK;
    logic [7:0]  VDATA;
    logic        VDATA_VALID;
    logic [2:0]  PHASE;

    int n_checks;
    int n_errors;

    video_ram_arbiter dut (
        .PIXELCLK   (PIXELCLK),
        .RESET      (RESET),
        .VADDR      (VADDR),
        .WRAP_SEL   (WRAP_SEL),
        .CPU_REQ    (CPU_REQ),
        .CPU_WE     (CPU_WE),
        .CPU_ADDR   (CPU_ADDR),
        .CPU_WDATA  (CPU_WDATA),
        .RAM_DIN    (RAM_DIN),
        .RAM_ADDR   (RAM_ADDR),
        .RAM_WE     (RAM_WE),
        .RAM_DOUT   (RAM_DOUT),
        .CPU_RDATA  (CPU_RDATA),
        .CPU_ACK    (CPU_ACK),
        .VDATA      (VDATA),
        .VDATA_VALID(VDATA_VALID),
        .PHASE      (PHASE)
    );

    initial PIXELCLK = 1'b0;
    always #5 PIXELCLK = ~PIXELCLK;

    function automatic logic [7:0] init_f(input logic [14:0] a);
        return a[7:0] ^ {a[14:8], 1'b1};
    endfunction

    // Video address the spec's wrap rule yields for a given VADDR/WRAP_SEL.
    function automatic logic [14:0] vmap(input logic [15:0] va, input logic [1:0] sel);
        int v;
`ifdef VIDEO_WRAP_EN
        int size;
        case (sel)
            2'd0:    size = 16384;
            2'd1:    size = 8192;
            2'd2:    size = 20480;
            default: size = 10240;
        endcase
        v = int'(va);
        if (v >= 32768) v = (v + 65536 - size) % 65536;
`else
        logic [1:0] unused_sel;
        unused_sel = sel;
        v = int'(va);
`endif
        return 15'(v % 32768);
    endfunction

    // Environment RAM: untouched locations read back init_f(addr).
    logic [7:0]     ram [0:32767];
    logic [32767:0] ram_vld;
    logic           mem_clr;

    assign RAM_DIN = ram_vld[RAM_ADDR] ? ram[RAM_ADDR] : init_f(RAM_ADDR);

    always @(posedge PIXELCLK) begin
        if (mem_clr) begin
            ram_vld <= '0;
        end else if (RAM_WE) begin
            ram[RAM_ADDR]     <= RAM_DOUT;
            ram_vld[RAM_ADDR] <= 1'b1;
        end
    end

    // Model: slot phase counts edges since reset; video address is taken at phase 7.
    logic [2:0]  m_phase;
    logic [14:0] m_video;
    logic [7:0]  ref_mem [0:32767];

    always @(posedge PIXELCLK) begin
        if (RESET) begin
            m_phase <= 3'd0;
            m_video <= 15'd0;
        end else begin
            m_phase <= m_phase + 3'd1;
            if (m_phase == 3'd7) m_video <= vmap(VADDR, WRAP_SEL);
        end
    end

    task automatic tick();
        @(posedge PIXELCLK);
        #1;
    endtask

    task automatic wait_phase(input logic [2:0] p);
        for (int i = 0; i < 8 && m_phase != p; i++) tick();
    endtask

    // One CPU transfer issued now; the next edge samples it at phase m_phase.
    task automatic xfer(input logic we, input logic [14:0] addr, input logic [7:0] wdata);
        int          p;
        int          lat;
        logic        in_acc;
        logic        exp_we;
        logic [14:0] exp_addr;
        p   = int'(m_phase);
        lat = ((11 - p) % 8) + 5;
        CPU_REQ   = 1'b1;
        CPU_WE    = we;
        CPU_ADDR  = addr;
        CPU_WDATA = wdata;
        for (int n = 1; n <= lat; n++) begin
            tick();
            if (n == lat - 4) begin
                CPU_ADDR  = ~addr;
                CPU_WDATA = ~wdata;
                CPU_WE    = ~we;
            end
            in_acc   = (n >= lat - 4) && (n <= lat - 1);
            exp_addr = in_acc ? addr : m_video;
            exp_we   = we && ((n == lat - 3) || (n == lat - 2));
            n_checks++;
            if (PHASE !== m_phase) begin
                n_errors++;
                $display("FAIL xfer_phase n=%0d got=%0d exp=%0d", n, PHASE, m_phase);
            end
            n_checks++;
            if (RAM_ADDR !== exp_addr) begin
                n_errors++;
                $display("FAIL xfer_ram_addr n=%0d got=%h exp=%h", n, RAM_ADDR, exp_addr);
            end
            n_checks++;
            if (RAM_WE !== exp_we) begin
                n_errors++;
                $display("FAIL xfer_ram_we n=%0d got=%b exp=%b", n, RAM_WE, exp_we);
            end
            n_checks++;
            if (CPU_ACK !== (n == lat)) begin
                n_errors++;
                $display("FAIL xfer_ack n=%0d lat=%0d got=%b", n, lat, CPU_ACK);
            end
            if (exp_we) begin
                n_checks++;
                if (RAM_DOUT !== wdata) begin
                    n_errors++;
                    $display("FAIL xfer_ram_dout got=%h exp=%h", RAM_DOUT, wdata);
                end
            end
            n_checks++;
            if (VDATA_VALID !== (m_phase == 3'd4)) begin
                n_errors++;
                $display("FAIL xfer_vvalid phase=%0d got=%b", m_phase, VDATA_VALID);
            end
            if (m_phase == 3'd4) begin
                n_checks++;
                if (VDATA !== ref_mem[m_video]) begin
                    n_errors++;
                    $display("FAIL xfer_vdata got=%h exp=%h", VDATA, ref_mem[m_video]);
                end
            end
        end
        if (!we) begin
            n_checks++;
            if (CPU_RDATA !== ref_mem[addr]) begin
                n_errors++;
                $display("FAIL xfer_rdata got=%h exp=%h", CPU_RDATA, ref_mem[addr]);
            end
        end else begin
            ref_mem[addr] = wdata;
        end
        CPU_REQ = 1'b0;
        tick();
        n_checks++;
        if (CPU_ACK !== 1'b0) begin
            n_errors++;
            $display("FAIL xfer_ack_width got=%b exp=0", CPU_ACK);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({PHASE, RAM_ADDR, RAM_WE, RAM_DOUT} !== 27'd0) begin
            n_errors++;
            $display("FAIL reset_ram phase=%0d addr=%h we=%b dout=%h", PHASE, RAM_ADDR, RAM_WE,
                     RAM_DOUT);
        end
        n_checks++;
        if ({CPU_RDATA, CPU_ACK, VDATA, VDATA_VALID} !== 18'd0) begin
            n_errors++;
            $display("FAIL reset_out rdata=%h ack=%b vdata=%h vvalid=%b", CPU_RDATA, CPU_ACK,
                     VDATA, VDATA_VALID);
        end
        RESET = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_checks++;
            if (PHASE !== 3'(i % 8)) begin
                n_errors++;
                $display("FAIL reset_phase_seq i=%0d got=%0d exp=%0d", i, PHASE, i % 8);
            end
            n_checks++;
            if (VDATA_VALID !== (i == 4)) begin
                n_errors++;
                $display("FAIL reset_vvalid i=%0d got=%b", i, VDATA_VALID);
            end
            n_checks++;
            if (RAM_WE !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_ram_we i=%0d got=%b exp=0", i, RAM_WE);
            end
        end
    endtask

    task automatic test_min_write();
        wait_phase(3'd3);
        xfer(1'b1, 15'h1234, 8'hA5);
    endtask

    task automatic test_max_read();
        wait_phase(3'd3);
        xfer(1'b1, 15'h0400, 8'h3C);
        wait_phase(3'd4);
        xfer(1'b0, 15'h0400, 8'h00);
        n_checks++;
        if (CPU_RDATA !== 8'h3C) begin
            n_errors++;
            $display("FAIL max_read_rdata got=%h exp=3c", CPU_RDATA);
        end
    endtask

    task automatic test_wrap();
        logic [14:0] exp_tab [4];
`ifdef VIDEO_WRAP_EN
        exp_tab = '{15'h4100, 15'h6100, 15'h3100, 15'h5900};
`else
        exp_tab = '{15'h0100, 15'h0100, 15'h0100, 15'h0100};
`endif
        for (int s = 0; s < 4; s++) begin
            VADDR    = 16'h8100;
            WRAP_SEL = 2'(s);
            wait_phase(3'd7);
            tick();
            n_checks++;
            if (RAM_ADDR !== exp_tab[s]) begin
                n_errors++;
                $display("FAIL wrap sel=%0d got=%h exp=%h", s, RAM_ADDR, exp_tab[s]);
            end
        end
    endtask

    task automatic test_cancel();
        wait_phase(3'd5);
        CPU_REQ   = 1'b1;
        CPU_WE    = 1'b1;
        CPU_ADDR  = 15'h1555;
        CPU_WDATA = 8'h11;
        tick();
        CPU_REQ = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            n_checks++;
            if ({RAM_WE, CPU_ACK} !== 2'b00) begin
                n_errors++;
                $display("FAIL cancel i=%0d we=%b ack=%b exp=0", i, RAM_WE, CPU_ACK);
            end
            n_checks++;
            if (RAM_ADDR !== m_video) begin
                n_errors++;
                $display("FAIL cancel_addr i=%0d got=%h exp=%h", i, RAM_ADDR, m_video);
            end
        end
    endtask

    task automatic test_abort();
        wait_phase(3'd3);
        CPU_REQ   = 1'b1;
        CPU_WE    = 1'b1;
        CPU_ADDR  = 15'h7F00;
        CPU_WDATA = 8'hEE;
        tick();
        tick();
        n_checks++;
        if (RAM_WE !== 1'b1) begin
            n_errors++;
            $display("FAIL abort_we_before got=%b exp=1", RAM_WE);
        end
        RESET   = 1'b1;
        CPU_REQ = 1'b0;
        tick();
        n_checks++;
        if ({RAM_WE, PHASE} !== 4'd0) begin
            n_errors++;
            $display("FAIL abort_reset_edge we=%b phase=%0d exp=0", RAM_WE, PHASE);
        end
        // The reset edge itself still saw the phase-5 strobe, so RAM took the byte.
        ref_mem[15'h7F00] = 8'hEE;
        RESET = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            n_checks++;
            if ({RAM_WE, CPU_ACK} !== 2'b00) begin
                n_errors++;
                $display("FAIL abort_after i=%0d we=%b ack=%b exp=0", i, RAM_WE, CPU_ACK);
            end
        end
    endtask

    task automatic test_video_fetch();
        wait_phase(3'd3);
        xfer(1'b1, 15'h0200, 8'h81);
        VADDR    = 16'h0200;
        WRAP_SEL = 2'd0;
        wait_phase(3'd7);
        tick();
        wait_phase(3'd3);
        n_checks++;
        if (RAM_ADDR !== 15'h0200) begin
            n_errors++;
            $display("FAIL vfetch_addr got=%h exp=0200", RAM_ADDR);
        end
        CPU_REQ   = 1'b1;
        CPU_WE    = 1'b1;
        CPU_ADDR  = 15'h0200;
        CPU_WDATA = 8'h5A;
        for (int n = 1; n <= 5; n++) begin
            tick();
            if (n <= 4) begin
                n_checks++;
                if ({VDATA, VDATA_VALID} !== {8'h81, n == 1}) begin
                    n_errors++;
                    $display("FAIL vfetch n=%0d vdata=%h vvalid=%b exp=81/%b", n, VDATA,
                             VDATA_VALID, n == 1);
                end
            end
            n_checks++;
            if (CPU_ACK !== (n == 5)) begin
                n_errors++;
                $display("FAIL vfetch_ack n=%0d got=%b", n, CPU_ACK);
            end
        end
        CPU_REQ = 1'b0;
        ref_mem[15'h0200] = 8'h5A;
        wait_phase(3'd4);
        n_checks++;
        if ({VDATA, VDATA_VALID} !== {8'h5A, 1'b1}) begin
            n_errors++;
            $display("FAIL vfetch_next vdata=%h vvalid=%b exp=5a/1", VDATA, VDATA_VALID);
        end
    endtask

    task automatic test_random();
        int gap;
        for (int t = 0; t < 40; t++) begin
            VADDR    = 16'($urandom);
            WRAP_SEL = 2'($urandom_range(0, 3));
            gap      = int'($urandom_range(0, 9));
            repeat (gap) tick();
            xfer(1'($urandom_range(0, 1)), 15'(15'h1000 + $urandom_range(0, 4095)),
                 8'($urandom));
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        RESET     = 1'b1;
        mem_clr   = 1'b1;
        VADDR     = 16'h0000;
        WRAP_SEL  = 2'd0;
        CPU_REQ   = 1'b0;
        CPU_WE    = 1'b0;
        CPU_ADDR  = 15'd0;
        CPU_WDATA = 8'd0;
        for (int i = 0; i < 32768; i++) ref_mem[i] = init_f(15'(i));
        tick();
        mem_clr = 1'b0;
        test_reset();
        test_min_write();
        test_max_read();
        test_wrap();
        test_cancel();
        test_abort();
        test_video_fetch();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/video_ram_arbiter.md
VIDEO_RAM_ARBITER -- requirements
Module: video_ram_arbiter

Interface
REQ-001 The block SHALL have exactly these ports, with clock and reset first:
- PIXELCLK  in  1  16 MHz pixel clock; all logic on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- VADDR  in  16  video byte address from the CRTC address mapper.
- WRAP_SEL  in  2  screen-size select for hardware-scroll wrap.
- CPU_REQ  in  1  CPU access request; held high until CPU_ACK.
- CPU_WE  in  1  1 = write, 0 = read; qualified by CPU_REQ.
- CPU_ADDR  in  15  CPU RAM address.
- CPU_WDATA  in  8  CPU write data.
- RAM_DIN  in  8  read data from the shared RAM.
- RAM_ADDR  out  15  shared RAM address.
- RAM_WE  out  1  shared RAM write strobe.
- RAM_DOUT  out  8  shared RAM write data.
- CPU_RDATA  out  8  CPU read data.
- CPU_ACK  out  1  one-cycle completion pulse.
- VDATA  out  8  video byte for the pixel shifter.
- VDATA_VALID  out  1  one-cycle pulse when VDATA updates.
- PHASE  out  3  current slot phase.
REQ-002 All outputs SHALL be registered.

Function
REQ-003 PHASE SHALL increment by 1 every PIXELCLK, wrapping 7 -> 0. The period is 8 cycles (2 MHz).
REQ-004 Phases 0-3 SHALL form the video slot, and phases 4-7 SHALL form the CPU slot.
REQ-005 On the edge where PHASE==7, the block SHALL sample VADDR and compute the wrapped address. RAM_ADDR SHALL carry that address during phases 0-3.
REQ-006 Wrap rule: if VADDR[15]=1, the result SHALL be (VADDR - SIZE)[14:0]; otherwise it SHALL be VADDR[14:0]. SIZE SHALL be selected by WRAP_SEL: 00=0x4000, 01=0x2000, 10=0x5000, 11=0x2800. The subtraction SHALL be modulo 2^16.
REQ-007 On the edge where PHASE==3, VDATA SHALL capture RAM_DIN. VDATA_VALID SHALL be 1 for exactly the following cycle (PHASE==4).
REQ-008 The CPU state machine SHALL have the states IDLE, WAIT, ACCESS and DONE.
REQ-009 From IDLE, CPU_REQ=1 sampled on the edge where PHASE==3 SHALL go to ACCESS. CPU_REQ=1 sampled at any other phase SHALL go to WAIT.
REQ-010 From WAIT, the machine SHALL go to ACCESS on the edge where PHASE==3. If CPU_REQ=0 is sampled while in WAIT, the machine SHALL return to IDLE (cancel, no RAM access).
REQ-011 On entry to ACCESS, the block SHALL latch CPU_ADDR, CPU_WE and CPU_WDATA. Changes to CPU inputs during ACCESS SHALL be ignored.
REQ-012 In ACCESS, RAM_ADDR SHALL equal the latched CPU_ADDR for phases 4-7.
- Write: RAM_DOUT = latched data, and RAM_WE=1 during phases 5 and 6 only.
- Read: RAM_WE SHALL stay 0.
REQ-013 ACCESS SHALL go to DONE on the edge where PHASE==7. On a read, CPU_RDATA SHALL capture RAM_DIN on that same edge.
REQ-014 DONE SHALL last one cycle (PHASE==0), with CPU_ACK=1. It SHALL then return to IDLE.
REQ-015 CPU_REQ sampled while in DONE SHALL be ignored. A new request is sampled from IDLE at the following edge.
REQ-016 In a CPU slot with no ACCESS, RAM_ADDR SHALL hold the video address and RAM_WE SHALL be 0.
REQ-017 Latency from the sampling edge to CPU_ACK SHALL be:
- minimum 5 cycles (sampled at PHASE==3);
- maximum 12 cycles (sampled at PHASE==4).
REQ-018 The video slot SHALL never be granted to the CPU. RAM_WE SHALL be 0 in phases 0-4 and 7.

Reset
REQ-019 While RESET=1 at a clock edge, the block SHALL force the following on that edge:
- PHASE=0 and state=IDLE;
- RAM_ADDR=0, RAM_WE=0 and RAM_DOUT=0;
- CPU_RDATA=0, CPU_ACK=0, VDATA=0 and VDATA_VALID=0.
REQ-020 Reset mid-ACCESS SHALL abort the transfer. RAM_WE SHALL be deasserted on the reset edge, and no CPU_ACK SHALL be issued for the aborted request.
REQ-021 After RESET falls, the first edge SHALL produce PHASE=1. CPU_REQ held across reset SHALL be treated as a new request.

Configuration
REQ-022 When macro VIDEO_WRAP_EN is defined, REQ-006 wrap subtraction SHALL be implemented.
REQ-023 When VIDEO_WRAP_EN is undefined, the video address SHALL be VADDR[14:0] unmodified, and WRAP_SEL SHALL be ignored.

Verification
REQ-024 Reset check: hold RESET 2 cycles, then release. Required: PHASE sequence 1,2,...,7,0; VDATA_VALID pulses only at PHASE==4; RAM_WE=0 throughout.
REQ-025 Minimum-latency write: CPU_REQ=1, CPU_WE=1, CPU_ADDR=0x1234, CPU_WDATA=0xA5, asserted so it is sampled at PHASE==3. Required: RAM_ADDR=0x1234 in phases 4-7; RAM_WE=1 at phases 5 and 6; RAM_DOUT=0xA5; CPU_ACK at PHASE==0, 5 cycles later.
REQ-026 Maximum-latency read: request sampled at PHASE==4 with CPU_ADDR=0x0400 and RAM_DIN=0x3C in the CPU slot. Required: CPU_RDATA=0x3C, and CPU_ACK 12 cycles after sampling.
REQ-027 Wrap, with VIDEO_WRAP_EN defined: VADDR=0x8100 with WRAP_SEL = 00, 01, 10, 11. Required RAM_ADDR: 0x4100, 0x6100, 0x3100, 0x5900. With the macro undefined: 0x0100.
REQ-028 Cancel and abort:
- CPU_REQ dropped while in WAIT: no RAM_WE and no CPU_ACK.
- RESET asserted at PHASE==5 of a write: RAM_WE=0 on the next cycle and no CPU_ACK.
REQ-029 Video fetch: RAM_DIN=0x81 during phase 3. Required: VDATA=0x81 with VDATA_VALID=1 at PHASE==4, unaffected by a concurrent CPU write.
